// File: rtl/decode_imm_ctrl.sv
// decode_imm_ctrl: single-stage RV32I decode front end.
// Registers each fetched instruction and its PC behind a valid/ready handshake.
// Decodes the opcode into a one-hot immediate select for an external generator
// and qualifies the returned immediate. Holds the front end after a SYSTEM
// instruction is handed off until resume. Counts back-pressure stall cycles.
module decode_imm_ctrl #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [31:0]       if_instr,
  input  logic [PC_W-1:0]   if_pc,
  input  logic              flush,
  input  logic              resume,
  output logic [31:0]       gen_instr,
  output logic [4:0]        gen_sel,
  input  logic [31:0]       gen_imm,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [31:0]       id_instr,
  output logic [PC_W-1:0]   id_pc,
  output logic [31:0]       id_imm,
  output logic [4:0]        id_imm_sel,
  output logic              id_illegal,
  output logic              hold,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // One-hot immediate select encodings: bit0 I, bit1 U, bit2 S, bit3 B, bit4 J
  localparam logic [4:0] SEL_NONE = 5'b00000;
  localparam logic [4:0] SEL_I    = 5'b00001;
  localparam logic [4:0] SEL_U    = 5'b00010;
  localparam logic [4:0] SEL_S    = 5'b00100;
  localparam logic [4:0] SEL_B    = 5'b01000;
  localparam logic [4:0] SEL_J    = 5'b10000;

  state_e           state_q, state_d;
  logic             valid_q, valid_d;
  logic [31:0]      instr_q, instr_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [4:0]       sel_q, sel_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [4:0]       dec_sel;
  logic             dec_illegal;
  logic             held_system;
  logic             accept;
  logic             handoff;

  // Decode the opcode of the instruction currently offered by fetch
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    dec_sel     = SEL_NONE;
    dec_illegal = 1'b0;
    case (if_instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111,
      7'b1110011, 7'b0001111:               dec_sel = SEL_I;
      7'b0110111, 7'b0010111:               dec_sel = SEL_U;
      7'b0100011:                           dec_sel = SEL_S;
      7'b1100011:                           dec_sel = SEL_B;
      7'b1101111:                           dec_sel = SEL_J;
      7'b0110011:                           dec_sel = SEL_NONE;
      default:                              dec_illegal = 1'b1;
    endcase
  end

  // A held SYSTEM instruction blocks acceptance in its hand-off cycle
  assign held_system = valid_q && (instr_q[6:0] == OPC_SYSTEM);
  assign if_ready    = !rst && !flush && (state_q == ST_RUN)
                       && (!valid_q || id_ready) && !held_system;
  assign id_valid    = valid_q && !rst;
  assign accept      = if_valid && if_ready;
  assign handoff     = id_valid && id_ready;

  // Next-state logic for the pipeline register and the RUN/HOLD sequencer
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    instr_d   = instr_q;
    pc_d      = pc_q;
    sel_d     = sel_q;
    illegal_d = illegal_q;
    if (flush) begin
      state_d = ST_RUN;
      valid_d = 1'b0;
      instr_d = '0;
      pc_d    = '0;
      sel_d   = SEL_NONE;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (accept) begin
            valid_d   = 1'b1;
            instr_d   = if_instr;
            pc_d      = if_pc;
            sel_d     = dec_sel;
            illegal_d = dec_illegal;
          end else if (handoff) begin
            valid_d = 1'b0;
            if (held_system) state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          valid_d = 1'b0;
          if (resume) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // Saturating count of cycles where downstream refuses a valid instruction
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (id_valid && !id_ready && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= ST_RUN;
      valid_q     <= 1'b0;
      instr_q     <= '0;
      pc_q        <= '0;
      sel_q       <= SEL_NONE;
      illegal_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      sel_q       <= sel_d;
      illegal_q   <= illegal_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign gen_instr  = instr_q;
  assign gen_sel    = sel_q;
  // R-type and illegal opcodes carry no immediate; suppress the generator's
  // default output for them.
  assign id_imm     = (sel_q != SEL_NONE) ? gen_imm : 32'h0;
  assign id_instr   = instr_q;
  assign id_pc      = pc_q;
  assign id_imm_sel = sel_q;
  assign id_illegal = illegal_q;
  assign hold       = (state_q == ST_HOLD);
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: doc/decode_imm_ctrl.md
Name: decode_imm_ctrl

Overview:
- Single-stage RV32I decode-front controller between the fetch stage and the execute stage.
- Registers each fetched instruction and PC behind a valid/ready handshake.
- Decodes the opcode into the one-hot immediate select, drives the external immediate generator, and presents the qualified immediate downstream.
- Sequences SYSTEM instructions: after one is handed off, it holds the front end until an explicit resume. Also keeps a back-pressure stall counter.

Parameters:
- PC_W, 32, width of the program counter carried with each instruction
- CNT_W, 16, width of the saturating stall counter

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- if_valid  input  1  fetch offers an instruction
- if_ready  output  1  this stage accepts the offered instruction
- if_instr  input  32  fetched instruction
- if_pc  input  PC_W  PC of fetched instruction
- flush  input  1  discard the held instruction and return to RUN
- resume  input  1  release the SYSTEM hold
- gen_instr  output  32  instruction driven to the immediate generator
- gen_sel  output  5  one-hot immediate select to the generator: bit0 I, bit1 U, bit2 S, bit3 B, bit4 J
- gen_imm  input  32  immediate returned combinationally by the generator
- id_valid  output  1  decoded instruction available
- id_ready  input  1  execute stage accepts
- id_instr  output  32  held instruction
- id_pc  output  PC_W  held PC
- id_imm  output  32  qualified immediate
- id_imm_sel  output  5  registered one-hot select
- id_illegal  output  1  held opcode is not RV32I
- hold  output  1  controller is in HOLD state
- stall_cnt  output  CNT_W  cycles with id_valid and not id_ready

Behaviour:
- Reset (rst high at a clk edge) clears all state:
  - valid_q, id_instr, id_pc, id_imm_sel, id_illegal, stall_cnt all 0; state = RUN.
  - Consequently id_valid=0, id_imm=0, hold=0, gen_instr=0, gen_sel=0.
  - if_ready is forced 0 while rst is high.
- Decode of opcode instr[6:0], computed at acceptance and registered:
  - 0010011, 0000011, 1100111, 1110011, 0001111 -> I (00001)
  - 0110111, 0010111 -> U (00010)
  - 0100011 -> S (00100)
  - 1100011 -> B (01000)
  - 1101111 -> J (10000)
  - 0110011 -> 00000, legal
  - any other opcode -> 00000 with illegal=1
- Generator interface and immediate qualification:
  - gen_instr = id_instr; gen_sel = id_imm_sel.
  - id_imm = gen_imm when id_imm_sel != 0, else 32'h0. This covers R-type and illegal opcodes; the generator's default J result is never passed through.
- Handshake: if_ready = !rst && state==RUN && (!valid_q || id_ready).
  - An acceptance (if_valid && if_ready) at edge N loads the register; id_valid=1 from cycle N+1. Latency is 1 cycle.
  - Full throughput: back-to-back transfers occur when id_ready is held high.
  - Hand-off (id_valid && id_ready) without a simultaneous acceptance clears valid_q.
  - While id_valid && !id_ready, the held id_* outputs stay stable.
- FSM states RUN and HOLD:
  - RUN -> HOLD when a hand-off occurs on an instruction with opcode 1110011. No new instruction is accepted in that cycle: if_ready is deasserted combinationally when the held opcode is SYSTEM.
  - HOLD: if_ready=0, hold=1, valid_q=0.
  - HOLD -> RUN on resume. if_ready rises in the cycle after resume.
  - resume while in RUN is ignored.
- flush, priority over acceptance, hand-off and resume (rst has priority over flush):
  - Next valid_q=0, next state=RUN. Registered id_instr, id_pc and id_imm_sel are also cleared to 0.
  - An instruction offered in the flush cycle is not accepted: if_ready=0 while flush=1.
- stall_cnt increments by 1 in each cycle with id_valid && !id_ready. It saturates at all-ones and is never cleared except by rst.
- Reset mid-transfer: the held instruction is lost, and no hand-off is reported in the reset cycle (id_valid=0 once rst is sampled).

Test Plan:
- Reset, then offer if_instr=32'h00500093 (addi x1,x0,5), pc=0x100, with id_ready=1 -> id_valid=1 the next cycle, gen_sel=00001, id_imm=5, id_pc=0x100.
- Stream lui 32'h123450B7, sw 32'hFE112E23, beq 32'hFE000EE3, jal 32'h008000EF back-to-back with id_ready=1 -> one transfer per cycle. gen_sel=00010/00100/01000/10000; id_imm=0x12345000/-4/-4/8.
- add 32'h002081B3, then opcode 1111111 -> id_imm=0 for both; id_illegal=0 then 1; id_imm_sel=0.
- Hold id_ready=0 for 5 cycles with an instruction held -> outputs stable, if_ready=0, stall_cnt=5. Preload the counter near max to check saturation at 0xFFFF.
- ecall 32'h00000073 handed off -> hold=1 and if_ready=0 for 10 cycles with if_valid=1. Pulse resume -> if_ready=1 the next cycle, and the next instruction flows through.
- flush asserted with a held instruction and id_ready=0 -> id_valid=0 the next cycle. Repeat with flush and resume asserted together in HOLD -> RUN, and if_ready=1 the next cycle.
